// File: rtl/fx_arb_if.sv
// fx_arb_if: two request/ack master ports plus the shared fx register bus.
interface fx_arb_if;
    logic        m0_req;
    logic        m0_we;
    logic [21:0] m0_addr;
    logic [7:0]  m0_wdata;
    logic        m0_ack;
    logic [7:0]  m0_rdata;
    logic        m1_req;
    logic        m1_we;
    logic [21:0] m1_addr;
    logic [7:0]  m1_wdata;
    logic        m1_ack;
    logic [7:0]  m1_rdata;
    logic        fx_wr;
    logic [21:0] fx_waddr;
    logic [7:0]  fx_data;
    logic        fx_rd;
    logic [21:0] fx_raddr;
    logic [7:0]  fx_q;
    logic        arb_busy;
    logic        arb_gnt;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, fx_q,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata, fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
               arb_busy, arb_gnt
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, fx_q,
        output m0_ack, m0_rdata, m1_ack, m1_rdata, fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
               arb_busy, arb_gnt
    );
endinterface

// File: rtl/fx_arb.sv
// fx_arb: two-master arbiter/sequencer for the fx register bus.
// FX_ARB_M0_PRI_EN selects fixed m0 priority; undefined gives round-robin.
module fx_arb #(
    parameter int unsigned RD_LAT = 1
) (
    input logic     clk_sys,
    input logic     rst_n,
    fx_arb_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RDONE} state_t;

    state_t      state, state_n;
    logic        last, pick, grant, sel_we, gnt_n, ack_n, cap;
    logic [21:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic [2:0]  cnt;

    // pick the winner and decode the next state
    always_comb begin
`ifdef FX_ARB_M0_PRI_EN
        pick = !bus.m0_req;
`else
        pick = bus.m0_req && bus.m1_req ? !last : bus.m1_req;
`endif
        grant = state == IDLE && (bus.m0_req || bus.m1_req);
        sel_we = pick ? bus.m1_we : bus.m0_we;
        sel_addr = pick ? bus.m1_addr : bus.m0_addr;
        sel_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
        gnt_n = grant ? pick : bus.arb_gnt;
        cap = state == RWAIT && cnt == 3'd0;
        state_n = IDLE;
        case (state)
            IDLE:    state_n = grant ? (sel_we ? WR : RD) : IDLE;
            RD:      state_n = RWAIT;
            RWAIT:   state_n = cap ? RDONE : RWAIT;
            default: state_n = IDLE;
        endcase
        ack_n = state_n == WR || state_n == RDONE;
    end

    // state, read-latency counter and round-robin pointer
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= 3'd0;
            last <= 1'b1;
        end else begin
            state <= state_n;
            cnt <= state == RD ? 3'(RD_LAT - 1) : (state == RWAIT && !cap) ? cnt - 3'd1 : cnt;
            last <= grant ? pick : last;
        end
    end

    // registered bus strobes, held addresses/data, acks and read data
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            bus.fx_wr <= 1'b0;
            bus.fx_rd <= 1'b0;
            bus.fx_waddr <= 22'd0;
            bus.fx_data <= 8'd0;
            bus.fx_raddr <= 22'd0;
            bus.m0_ack <= 1'b0;
            bus.m1_ack <= 1'b0;
            bus.m0_rdata <= 8'd0;
            bus.m1_rdata <= 8'd0;
            bus.arb_busy <= 1'b0;
            bus.arb_gnt <= 1'b0;
        end else begin
            bus.fx_wr <= state_n == WR;
            bus.fx_rd <= state_n == RD;
            bus.fx_waddr <= grant && sel_we ? sel_addr : bus.fx_waddr;
            bus.fx_data <= grant && sel_we ? sel_wdata : bus.fx_data;
            bus.fx_raddr <= grant && !sel_we ? sel_addr : bus.fx_raddr;
            bus.m0_ack <= ack_n && !gnt_n;
            bus.m1_ack <= ack_n && gnt_n;
            bus.m0_rdata <= cap && !bus.arb_gnt ? bus.fx_q : bus.m0_rdata;
            bus.m1_rdata <= cap && bus.arb_gnt ? bus.fx_q : bus.m1_rdata;
            bus.arb_busy <= state_n != IDLE;
            bus.arb_gnt <= gnt_n;
        end
    end
endmodule

// File: tb/tb_fx_arb.sv
// tb_fx_arb: randomized transaction-level check of fx_arb against a reference model.
module tb_fx_arb;
    localparam int RD_LAT = 1;

    logic clk_sys = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    fx_arb_if bus();
    fx_arb_if bus3();

    fx_arb #(.RD_LAT(RD_LAT)) dut (.clk_sys(clk_sys), .rst_n(rst_n), .bus(bus));
    fx_arb #(.RD_LAT(3)) dut3 (.clk_sys(clk_sys), .rst_n(rst_n), .bus(bus3));

    int total = 0;
    int bad = 0;

    logic        pend [2];
    logic        p_we [2];
    logic [21:0] p_addr [2];
    logic [7:0]  p_wd [2];

    logic        m_last;
    logic [7:0]  m_rdata [2];
    logic [7:0]  m_mem [logic [21:0]];

    logic [7:0]  slv_mem [logic [21:0]];
    logic [7:0]  pipe [RD_LAT];
    logic [7:0]  pipe3 [3];

    function automatic logic [7:0] dflt(input logic [21:0] a);
        return a[21:16] == 6'h3F ? 8'h00 : a[7:0];
    endfunction

    // behavioural slaves: registered read with RD_LAT cycles of latency
    always @(posedge clk_sys) begin
        if (bus.fx_wr && bus.fx_waddr[21:16] != 6'h3F) slv_mem[bus.fx_waddr] = bus.fx_data;
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= 8'h00;
            for (int i = 0; i < 3; i++) pipe3[i] <= 8'h00;
        end else begin
            pipe[0] <= !bus.fx_rd ? 8'h00 : slv_mem.exists(bus.fx_raddr) ? slv_mem[bus.fx_raddr] : dflt(bus.fx_raddr);
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
            pipe3[0] <= bus3.fx_rd ? dflt(bus3.fx_raddr) : 8'h00;
            pipe3[1] <= pipe3[0];
            pipe3[2] <= pipe3[1];
        end
    end
    assign bus.fx_q = pipe[RD_LAT-1];
    assign bus3.fx_q = pipe3[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.m0_req = pend[0];
        bus.m0_we = p_we[0];
        bus.m0_addr = p_addr[0];
        bus.m0_wdata = p_wd[0];
        bus.m1_req = pend[1];
        bus.m1_we = p_we[1];
        bus.m1_addr = p_addr[1];
        bus.m1_wdata = p_wd[1];
    endtask

    task automatic set_cmd(input logic m, input logic we, input logic [21:0] a, input logic [7:0] d);
        pend[m] = 1'b1;
        p_we[m] = we;
        p_addr[m] = a;
        p_wd[m] = d;
    endtask

    task automatic new_cmd(input logic m);
        logic [5:0] dev;
        int sel;
        sel = $urandom_range(2);
        dev = sel == 0 ? 6'h01 : sel == 1 ? 6'h02 : 6'h3F;
        set_cmd(m, 1'($urandom_range(1)), {dev, 14'h0, 2'($urandom_range(3))}, 8'($urandom));
    endtask

    function automatic logic [7:0] ref_rd(input logic [21:0] a);
        if (a[21:16] == 6'h3F) return 8'h00;
        return m_mem.exists(a) ? m_mem[a] : a[7:0];
    endfunction

    // one arbitrated transaction, entered during an IDLE cycle; leaves in the next IDLE cycle
    task automatic run_txn(output logic w);
        int n;
        logic we;
        logic [21:0] a;
        logic [7:0] d, exp_q;
        drive();
`ifdef FX_ARB_M0_PRI_EN
        w = pend[0] ? 1'b0 : 1'b1;
`else
        w = (pend[0] && pend[1]) ? !m_last : !pend[0];
`endif
        m_last = w;
        we = p_we[w];
        a = p_addr[w];
        d = p_wd[w];
        n = we ? 1 : 2 + RD_LAT;
        exp_q = ref_rd(a);
        if (we && a[21:16] != 6'h3F) m_mem[a] = d;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk_sys);
            #1;
            check("busy", bus.arb_busy, 1);
            check("fx_wr", bus.fx_wr, k == 1 && we);
            check("fx_rd", bus.fx_rd, k == 1 && !we);
            check("ack_win", w ? bus.m1_ack : bus.m0_ack, k == n);
            check("ack_lose", w ? bus.m0_ack : bus.m1_ack, 0);
            if (k == 1) begin
                check("gnt", bus.arb_gnt, w);
                if (we) begin
                    check("waddr", bus.fx_waddr, a);
                    check("wdata", bus.fx_data, d);
                end else begin
                    check("raddr", bus.fx_raddr, a);
                end
                if ($urandom_range(3) == 0) begin
                    pend[w] = 1'b0;
                    drive();
                end
            end
        end
        if (!we) m_rdata[w] = exp_q;
        check("rdata0", bus.m0_rdata, m_rdata[0]);
        check("rdata1", bus.m1_rdata, m_rdata[1]);
        pend[w] = 1'b0;
        drive();
        @(posedge clk_sys);
        #1;
        check("idle_busy", bus.arb_busy, 0);
        check("idle_strobes", {bus.fx_wr, bus.fx_rd, bus.m0_ack, bus.m1_ack}, 0);
    endtask

    initial begin
        logic w;
        logic order [4];
        pend = '{1'b0, 1'b0};
        p_we = '{1'b0, 1'b0};
        p_addr = '{22'h0, 22'h0};
        p_wd = '{8'h0, 8'h0};
        m_last = 1'b1;
        m_rdata = '{8'h00, 8'h00};
        drive();
        bus3.m0_req = 1'b0;
        bus3.m0_we = 1'b0;
        bus3.m0_addr = 22'h0;
        bus3.m0_wdata = 8'h0;
        bus3.m1_req = 1'b0;
        bus3.m1_we = 1'b0;
        bus3.m1_addr = 22'h0;
        bus3.m1_wdata = 8'h0;
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_strobes", {bus.fx_wr, bus.fx_rd, bus.m0_ack, bus.m1_ack, bus.arb_busy, bus.arb_gnt}, 0);
        check("rst_addr", {bus.fx_waddr, bus.fx_raddr}, 0);
        check("rst_data", {bus.fx_data, bus.m0_rdata, bus.m1_rdata}, 0);
        rst_n = 1'b1;

        set_cmd(0, 1'b1, 22'h010020, 8'h05);
        run_txn(w);
        set_cmd(0, 1'b0, 22'h010033, 8'h00);
        run_txn(w);
        set_cmd(0, 1'b0, 22'h3F0000, 8'h00);
        run_txn(w);
        check("unmapped_rdata", bus.m0_rdata, 8'h00);
        set_cmd(1, 1'b0, 22'h010080, 8'h00);
        run_txn(w);
        check("m1_read", bus.m1_rdata, 8'h80);

`ifdef FX_ARB_M0_PRI_EN
        order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        set_cmd(0, 1'b1, 22'h020001, 8'hA0);
        set_cmd(1, 1'b1, 22'h020002, 8'hB0);
        for (int i = 0; i < 4; i++) begin
            run_txn(w);
            check("tie_order", bus.arb_gnt, order[i]);
            set_cmd(w, 1'b1, w ? 22'h020002 : 22'h020001, 8'(i));
        end
        while (pend[0] || pend[1]) run_txn(w);

        set_cmd(0, 1'b0, 22'h010044, 8'h00);
        drive();
        @(posedge clk_sys);
        #1;
        check("mr_rd", bus.fx_rd, 1);
        @(posedge clk_sys);
        #1;
        check("mr_rwait", {bus.fx_rd, bus.arb_busy}, 2'b01);
        rst_n = 1'b0;
        @(posedge clk_sys);
        #1;
        check("mr_after", {bus.fx_rd, bus.arb_busy, bus.m0_ack, bus.m1_ack}, 0);
        rst_n = 1'b1;
        m_last = 1'b1;
        m_rdata = '{8'h00, 8'h00};
        pend[0] = 1'b1;
        run_txn(w);
        check("mr_reissue", bus.m0_rdata, 8'h44);

        for (int r = 0; r < 300; r++) begin
            for (int m = 0; m < 2; m++)
                if (!pend[m] && $urandom_range(2) != 0) new_cmd(1'(m));
            if (pend[0] || pend[1]) begin
                run_txn(w);
            end else begin
                drive();
                @(posedge clk_sys);
                #1;
                check("rand_idle", {bus.arb_busy, bus.m0_ack, bus.m1_ack}, 0);
            end
        end

        bus3.m0_addr = 22'h020011;
        bus3.m0_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk_sys);
            #1;
            check("l3_rd", bus3.fx_rd, k == 1);
            check("l3_ack", bus3.m0_ack, k == 5);
        end
        check("l3_rdata", bus3.m0_rdata, 8'h11);
        bus3.m0_req = 1'b0;
        @(posedge clk_sys);
        #1;
        check("l3_idle", {bus3.arb_busy, bus3.m0_ack}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
